// File: rtl/fpu_sig_pkg.sv
// rtl/fpu_sig_pkg.sv - shared types and constants for the FPU result signature block
package fpu_sig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

    // One MISR step: CRC-32 style shift with the result folded in afterwards.
    function automatic logic [31:0] misr_next(input logic [31:0] sig, input logic [31:0] data);
        logic [31:0] shifted;
        shifted = {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0000_0000);
        return shifted ^ data;
    endfunction

endpackage

// File: rtl/fpu_result_signature_if.sv
// rtl/fpu_result_signature_if.sv - FPU result stream feeding the signature block
interface fpu_result_signature_if;
    logic        res_valid;
    logic [31:0] res;
    logic        zflag;

    modport master (
        output res_valid,
        output res,
        output zflag
    );

    modport slave (
        input res_valid,
        input res,
        input zflag
    );
endinterface

// File: rtl/fpu_misr32.sv
// rtl/fpu_misr32.sv - 32-bit multiple-input signature register
module fpu_misr32
    import fpu_sig_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic [31:0] data,
    output logic [31:0] sig
);

    logic [31:0] sig_q;
    logic [31:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = MISR_SEED;
        end else if (en) begin
            sig_d = misr_next(sig_q, data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/fpu_result_signature.sv
// rtl/fpu_result_signature.sv - compacts N_SAMPLES FPU results into a MISR and reports pass/fail
// Optional zero-flag consistency check: FPU_SIG_ZCHECK_EN
module fpu_result_signature
    import fpu_sig_pkg::*;
#(
    parameter int          N_SAMPLES  = 1024,
    parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000,
    localparam int         CW         = $clog2(N_SAMPLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    fpu_result_signature_if.slave  res_if,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   zerr,
    output logic [31:0]            signature,
    output logic [CW-1:0]          sample_cnt,
    output logic [CW-1:0]          zcount
);

    state_e          state_q, state_d;
    logic [CW-1:0]   sample_cnt_q, sample_cnt_d;
    logic [CW-1:0]   zcount_q, zcount_d;
    logic            absorb;
    logic            clear;
    logic            last;

    // start is only honoured outside RUN; a sample in the start cycle is never absorbed
    assign absorb = (state_q == RUN) && res_if.res_valid;
    assign clear  = (state_q != RUN) && start;
    assign last   = (sample_cnt_q == CW'(N_SAMPLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (absorb && last) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        pass = (state_q == DONE) && (signature == GOLDEN_SIG) && !zerr;
    end

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        zcount_d     = zcount_q;
        if (clear) begin
            sample_cnt_d = '0;
            zcount_d     = '0;
        end else if (absorb) begin
            sample_cnt_d = sample_cnt_q + CW'(1);
            if (res_if.zflag) begin
                zcount_d = zcount_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt_q <= '0;
            zcount_q     <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            zcount_q     <= zcount_d;
        end
    end

`ifdef FPU_SIG_ZCHECK_EN
    logic zerr_q, zerr_d;
    logic res_is_zero;

    // Sign bit ignored so both +0 and -0 count as zero
    assign res_is_zero = (res_if.res[30:0] == 31'd0);

    always_comb begin
        zerr_d = zerr_q;
        if (clear) begin
            zerr_d = 1'b0;
        end else if (absorb && (res_if.zflag != res_is_zero)) begin
            zerr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zerr_q <= 1'b0;
        end else begin
            zerr_q <= zerr_d;
        end
    end

    assign zerr = zerr_q;
`else
    assign zerr = 1'b0;
`endif

    fpu_misr32 u_misr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (absorb),
        .data  (res_if.res),
        .sig   (signature)
    );

    assign sample_cnt = sample_cnt_q;
    assign zcount     = zcount_q;

endmodule

// File: tb/tb_fpu_result_signature.sv
// tb/tb_fpu_result_signature.sv - scoreboard bench for fpu_result_signature (N=1 and N=4 instances)
module tb_fpu_result_signature;

`ifdef FPU_SIG_ZCHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    localparam logic [31:0] SEED = 32'hFFFF_FFFF;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    typedef struct {
        logic [31:0] sig;
        int          cnt;
        int          zc;
        logic        zerr;
        logic        pass;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start1, start4;

    logic        busy1, done1, pass1, zerr1;
    logic [31:0] sig1;
    logic [0:0]  cnt1, zc1;
    logic        busy4, done4, pass4, zerr4;
    logic [31:0] sig4;
    logic [2:0]  cnt4, zc4;

    fpu_result_signature_if if1 ();
    fpu_result_signature_if if4 ();

    fpu_result_signature #(.N_SAMPLES(1), .GOLDEN_SIG(32'hFB3E_E249)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .res_if     (if1),
        .busy       (busy1),
        .done       (done1),
        .pass       (pass1),
        .zerr       (zerr1),
        .signature  (sig1),
        .sample_cnt (cnt1),
        .zcount     (zc1)
    );

    fpu_result_signature #(.N_SAMPLES(4), .GOLDEN_SIG(32'h0000_0000)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .res_if     (if4),
        .busy       (busy4),
        .done       (done4),
        .pass       (pass4),
        .zerr       (zerr4),
        .signature  (sig4),
        .sample_cnt (cnt4),
        .zcount     (zc4)
    );

    int n_vec  = 0;
    int n_fail = 0;

    exp_t q1[$];
    exp_t q4[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] s, input logic [31:0] d);
        logic [31:0] n;
        n = s << 1;
        if (s[31]) n = n ^ POLY;
        return n ^ d;
    endfunction

    // Monitor: each rising edge of done presents a finished run to the scoreboard
    logic done1_prev = 1'b0;
    logic done4_prev = 1'b0;
    exp_t e1, e4;

    always @(negedge clk) begin
        if (done1 === 1'b1 && done1_prev !== 1'b1) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected done", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("dut1 signature", sig1, e1.sig);
                chk("dut1 sample_cnt", {31'd0, cnt1}, e1.cnt);
                chk("dut1 zcount", {31'd0, zc1}, e1.zc);
                chk("dut1 zerr", {31'd0, zerr1}, {31'd0, e1.zerr});
                chk("dut1 pass", {31'd0, pass1}, {31'd0, e1.pass});
            end
        end
        if (done4 === 1'b1 && done4_prev !== 1'b1) begin
            if (q4.size() == 0) begin
                chk("dut4 unexpected done", 32'd1, 32'd0);
            end else begin
                e4 = q4.pop_front();
                chk("dut4 signature", sig4, e4.sig);
                chk("dut4 sample_cnt", {29'd0, cnt4}, e4.cnt);
                chk("dut4 zcount", {29'd0, zc4}, e4.zc);
                chk("dut4 zerr", {31'd0, zerr4}, {31'd0, e4.zerr});
                chk("dut4 pass", {31'd0, pass4}, {31'd0, e4.pass});
            end
        end
        done1_prev = done1;
        done4_prev = done4;
    end

    task automatic chk_reset4(input string tag);
        chk({tag, " busy"}, {31'd0, busy4}, 32'd0);
        chk({tag, " done"}, {31'd0, done4}, 32'd0);
        chk({tag, " pass"}, {31'd0, pass4}, 32'd0);
        chk({tag, " zerr"}, {31'd0, zerr4}, 32'd0);
        chk({tag, " signature"}, sig4, SEED);
        chk({tag, " sample_cnt"}, {29'd0, cnt4}, 32'd0);
        chk({tag, " zcount"}, {29'd0, zc4}, 32'd0);
    endtask

    task automatic send4(input logic [31:0] r, input logic z, input logic st);
        @(negedge clk);
        if4.res_valid = 1'b1;
        if4.res       = r;
        if4.zflag     = z;
        start4        = st;
    endtask

    task automatic idle4(input int n, input logic st);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if4.res_valid = 1'b0;
            start4        = st;
        end
    endtask

    task automatic run1(input logic [31:0] r, input logic z, input exp_t e);
        @(negedge clk);
        start1        = 1'b1;
        if1.res_valid = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        chk("dut1 busy after start", {31'd0, busy1}, 32'd1);
        chk("dut1 done low after start", {31'd0, done1}, 32'd0);
        q1.push_back(e);
        if1.res_valid = 1'b1;
        if1.res       = r;
        if1.zflag     = z;
        @(negedge clk);
        if1.res_valid = 1'b0;
        chk("dut1 done one cycle after sample", {31'd0, done1}, 32'd1);
        chk("dut1 busy low at done", {31'd0, busy1}, 32'd0);
    endtask

    logic [31:0] vd [4];
    logic        vz [4];
    logic [31:0] exp_sig;
    exp_t        e_run;

    initial begin
        rst = 1'b1;
        start1 = 1'b0;
        start4 = 1'b0;
        if1.res_valid = 1'b0; if1.res = '0; if1.zflag = 1'b0;
        if4.res_valid = 1'b0; if4.res = '0; if4.zflag = 1'b0;

        vd[0] = 32'h3F80_0000; vz[0] = 1'b0;
        vd[1] = 32'h0000_0000; vz[1] = 1'b1;
        vd[2] = 32'h4049_0FDB; vz[2] = 1'b0;
        vd[3] = 32'h8000_0000; vz[3] = 1'b1;
        exp_sig = SEED;
        for (int i = 0; i < 4; i++) exp_sig = model_step(exp_sig, vd[i]);
        e_run = '{sig: exp_sig, cnt: 4, zc: 2, zerr: 1'b0, pass: (exp_sig == 32'h0)};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset4("reset");
        chk("dut1 reset signature", sig1, SEED);
        chk("dut1 reset done", {31'd0, done1}, 32'd0);

        // Gapped run; start-cycle sample and mid-run start must be ignored
        q4.push_back(e_run);
        @(negedge clk);
        start4 = 1'b1;
        if4.res_valid = 1'b1; if4.res = 32'hDEAD_BEEF; if4.zflag = 1'b0;
        idle4(3, 1'b0);
        send4(vd[0], vz[0], 1'b0);
        send4(vd[1], vz[1], 1'b0);
        idle4(1, 1'b0);
        send4(vd[2], vz[2], 1'b1);
        idle4(1, 1'b1);
        idle4(1, 1'b0);
        send4(vd[3], vz[3], 1'b0);
        send4(32'hAAAA_5555, 1'b1, 1'b0);
        send4(32'h1234_5678, 1'b0, 1'b0);
        idle4(1, 1'b0);
        chk("dut4 done holds", {31'd0, done4}, 32'd1);
        chk("dut4 cnt after DONE samples", {29'd0, cnt4}, 32'd4);
        chk("dut4 sig after DONE samples", sig4, exp_sig);

        // Restart, abort with rst after two samples
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        chk("dut4 restart done", {31'd0, done4}, 32'd0);
        chk("dut4 restart busy", {31'd0, busy4}, 32'd1);
        chk("dut4 restart signature", sig4, SEED);
        chk("dut4 restart sample_cnt", {29'd0, cnt4}, 32'd0);
        send4(vd[0], vz[0], 1'b0);
        send4(vd[1], vz[1], 1'b0);
        @(negedge clk);
        if4.res_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset4("mid-run reset");

        // Clean back-to-back run after reset
        q4.push_back(e_run);
        @(negedge clk); start4 = 1'b1;
        for (int i = 0; i < 4; i++) send4(vd[i], vz[i], 1'b0);
        idle4(2, 1'b0);

        // Single-sample runs
        run1(32'h0000_0000, 1'b1, '{sig: 32'hFB3E_E249, cnt: 1, zc: 1, zerr: 1'b0, pass: 1'b1});
        run1(32'h3F80_0000, 1'b1, '{sig: 32'hC4BE_E249, cnt: 1, zc: 1, zerr: ZC, pass: 1'b0});
        run1(32'h0000_0000, 1'b0, '{sig: 32'hFB3E_E249, cnt: 1, zc: 0, zerr: ZC, pass: !ZC});
        run1(32'h8000_0000, 1'b1, '{sig: 32'h7B3E_E249, cnt: 1, zc: 1, zerr: 1'b0, pass: 1'b0});
        repeat (2) @(negedge clk);

        chk("scoreboard drained", q1.size() + q4.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_result_signature.md
# fpu_result_signature

Response-side self-test block for the FPU: consumes the FPU result stream (`OUT`, `zflag`) produced while a stimulus generator drives operands. It compacts a fixed number of results into a 32-bit MISR signature, counts zero-flag assertions and checks flag consistency. When the run completes, it reports pass or fail against a golden signature. It sits beside the FPU wrapper on-chip so a board run can be judged from a single `pass` bit.

## Interface
- `N_SAMPLES`, 1024, results absorbed per run (≥1)
- `GOLDEN_SIG`, 32'h0000_0000, expected final signature
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a run (honoured in IDLE/DONE only)
- `res_valid`  in  1  `res`/`zflag` valid this cycle
- `res`  in  32  FPU result (IEEE-754 single)
- `zflag`  in  1  FPU zero flag for `res`
- `busy`  out  1  run in progress
- `done`  out  1  run complete, results stable
- `pass`  out  1  `signature==GOLDEN_SIG` and no flag error; valid when `done`
- `zerr`  out  1  sticky zflag inconsistency seen this run
- `signature`  out  32  current MISR value
- `sample_cnt`  out  CW  samples absorbed, CW = $clog2(N_SAMPLES+1)
- `zcount`  out  CW  samples absorbed with `zflag`=1

## Operation
- States IDLE, RUN, DONE.
- IDLE: `start` → RUN; sig←SEED (32'hFFFF_FFFF), `sample_cnt`/`zcount`←0, `zerr`←0.
- RUN: each cycle with `res_valid`=1 absorbs one sample:
  - sig ← {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ `res`, with POLY=32'h04C1_1DB7.
  - `sample_cnt`+1; `zcount`+1 if `zflag`.
- RUN: `start` is ignored. `res_valid`=0 cycles leave all state unchanged (gaps allowed).
- RUN: the absorb that makes `sample_cnt`==N_SAMPLES also moves the FSM to DONE. No further samples are absorbed.
- DONE: all outputs hold. `start` → RUN with the same clearing as from IDLE. `res_valid` is ignored.
- Zero check (see Configuration): on an absorbed sample, `zflag` != (`res[30:0]`==0) sets `zerr`. Both ±0 count as zero.
- `pass` = DONE & (sig==GOLDEN_SIG) & ~`zerr`. It is 0 outside DONE.
- Counters cannot overflow, because absorption stops at N_SAMPLES.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `zerr`=0, `signature`=32'hFFFF_FFFF, `sample_cnt`=0, `zcount`=0; FSM=IDLE.
- `rst` mid-run returns the block to reset values on the next edge. The partial run is discarded.
- `start` sampled at edge T:
  - `busy`=1 after T.
  - A sample presented in the same cycle as `start` is not absorbed. The first absorbable sample is the one valid on the cycle after T.
- Absorption has 1-cycle latency: `signature`/counters reflect a sample after the edge that samples it.
- The final absorb at edge K gives `busy`=0, `done`=1 and valid `pass` after K, all in the same cycle.
- Restart from DONE: `done` falls and `busy` rises on the same edge.

## Configuration
- `FPU_SIG_ZCHECK_EN` defined: zero-flag consistency check is present and drives `zerr`, which gates `pass`.
- `FPU_SIG_ZCHECK_EN` undefined: no check logic; `zerr` is tied 0 and `pass` depends on the signature only. `zcount` remains present in both builds.

## Structure
- Package `fpu_sig_pkg` holds:
  - state enum (IDLE, RUN, DONE)
  - `MISR_POLY`=32'h04C1_1DB7
  - `MISR_SEED`=32'hFFFF_FFFF
- Sub-module `fpu_misr32` (inputs: clk, rst, clear, en, data; output: sig) holds the shift/XOR register. FSM, counters and checks live in the top.

## Test plan
- N_SAMPLES=1, start, one sample `res`=0, `zflag`=1 → `signature`=32'hFB3E_E249, `zcount`=1, `zerr`=0, `done`=1 one cycle after the sample. With GOLDEN_SIG=32'hFB3E_E249, `pass`=1.
- Zero-flag consistency (check compiled in):
  - `res`=32'h3F80_0000 with `zflag`=1 → `zerr`=1 and `pass`=0 even if the signature matches.
  - `res`=32'h8000_0000 with `zflag`=1 → `zerr`=0.
- Same zero-flag stimulus with the check compiled out → `zerr`=0, `pass` follows the signature only.
- N_SAMPLES=4, samples with `res_valid` gaps of 0–3 cycles, `start` pulsed mid-run → gaps and the mid-run `start` do not change the result. `sample_cnt`=4; the signature matches a software model.
- Boundary cases:
  - Sample presented in the `start` cycle is not absorbed.
  - Extra samples presented in DONE are not absorbed; `sample_cnt` stays 4.
- `rst` asserted after 2 of 4 samples → all outputs return to reset values. A fresh `start` then 4 samples → result identical to a clean run.
